// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
//
// Shares the single DSPI flash read port between two 16-bit word-read
// requesters. Port 0 is the chipset/CPU ROM fetch path and port 1 is the
// floppy/HDD image loader. The block drives the flash's edge-triggered
// cs/busy protocol, returns words over a req/ack handshake, and can keep a
// one-entry last-word buffer per port so that a repeated read of the same
// address is answered without touching the flash.
//
// Handshake (both ports): a requester raises pN_req with pN_addr stable and
// holds it until it sees pN_ack. pN_ack is a one-cycle pulse, asserted at
// least one cycle after req is sampled high, and pN_dout is valid in that
// cycle. The requester may drop req in the ack cycle or later. A port is not
// considered again in its ack cycle or in the cycle after it, so a req still
// high in those cycles is never mistaken for a new request.
//
// Parameters:
//   FIXED_PRIO    1: port 0 always wins a tie; 0: round-robin between ports.
//   CACHE_EN      1: enable the per-port last-word buffer.
//   ISSUE_TIMEOUT cycles to hold flash_cs waiting for flash_busy before the
//                 strobe is withdrawn and retried (4..15).
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   p0_req/p0_addr          port 0 request level and 22-bit word address
//   p0_ack/p0_dout          port 0 one-cycle ack and read data
//   p1_*                    same for port 1
//   flush                   invalidates both last-word buffers
//   flash_ready             flash init phase finished
//   flash_busy/flash_dout   flash transfer status and read data
//   flash_cs/flash_addr     read strobe (rising edge detected by the flash
//                           through a 2-flop synchroniser) and word address
//   grant                   port of the current or last flash access
//   dbg_state               FSM state (0 IDLE, 1 ISSUE, 2 BACKOFF, 3 WAIT)
// -----------------------------------------------------------------------------
module flash_arbiter #(
  parameter bit          FIXED_PRIO    = 1'b0,
  parameter bit          CACHE_EN      = 1'b1,
  parameter int unsigned ISSUE_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [21:0] p0_addr,
  output logic        p0_ack,
  output logic [15:0] p0_dout,
  input  logic        p1_req,
  input  logic [21:0] p1_addr,
  output logic        p1_ack,
  output logic [15:0] p1_dout,
  input  logic        flush,
  input  logic        flash_ready,
  input  logic        flash_busy,
  input  logic [15:0] flash_dout,
  output logic        flash_cs,
  output logic [21:0] flash_addr,
  output logic        grant,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BACKOFF = 2'd2,
    S_WAIT    = 2'd3
  } state_e;

  // Last value of the ISSUE cycle counter before the strobe is withdrawn.
  localparam logic [3:0] TMO_LAST = 4'(ISSUE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        bo_q, bo_d;
  logic [1:0]  hold_q, hold_d;
  logic        cs_q, cs_d;
  logic [21:0] faddr_q, faddr_d;
  logic        grant_q, grant_d;
  logic        rr_q, rr_d;
  logic        fill_ok_q, fill_ok_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  ack_dly_q;
  logic [15:0] dout_q [2];
  logic [15:0] dout_d [2];
  logic [21:0] buf_addr_q [2];
  logic [21:0] buf_addr_d [2];
  logic [15:0] buf_data_q [2];
  logic [15:0] buf_data_d [2];
  logic [1:0]  buf_vld_q, buf_vld_d;

  // Port inputs gathered into indexable form.
  logic [1:0]  req;
  logic [21:0] req_addr [2];

  assign req         = {p1_req, p0_req};
  assign req_addr[0] = p0_addr;
  assign req_addr[1] = p1_addr;

  // ---------------------------------------------------------------------------
  // Request classification and arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] pend;
  logic [1:0] hit;
  logic [1:0] miss;
  logic       win;
  logic       can_issue;

  always_comb begin
    pend = '0;
    hit  = '0;
    for (int p = 0; p < 2; p++) begin
      // A port is quiet in its ack cycle and the cycle after it.
      pend[p] = req[p] && !ack_q[p] && !ack_dly_q[p];
      // A flush in the same cycle already makes the buffer invalid.
      hit[p]  = CACHE_EN && buf_vld_q[p] && !flush &&
                (req_addr[p] == buf_addr_q[p]);
    end
    miss = pend & ~hit;
    if (miss == 2'b11) begin
      win = FIXED_PRIO ? 1'b0 : rr_q;
    end else begin
      win = miss[1];
    end
    // hold_q keeps the strobe quiet right after reset and right after an
    // access completes; flash_busy low means no transfer is still running.
    can_issue = flash_ready && !flash_busy && (hold_q == 2'd0) &&
                (miss != 2'b00);
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    bo_d       = bo_q;
    hold_d     = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    cs_d       = cs_q;
    faddr_d    = faddr_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    fill_ok_d  = fill_ok_q;
    ack_d      = '0;
    dout_d     = dout_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_vld_d  = buf_vld_q;

    unique case (state_q)
      S_IDLE: begin
        cs_d = 1'b0;
        if (flash_ready) begin
          // Buffer hits on both ports are answered independently.
          for (int p = 0; p < 2; p++) begin
            if (pend[p] && hit[p]) begin
              ack_d[p]  = 1'b1;
              dout_d[p] = buf_data_q[p];
            end
          end
          if (can_issue) begin
            faddr_d   = req_addr[win];
            grant_d   = win;
            rr_d      = ~win;
            fill_ok_d = 1'b1;
            cs_d      = 1'b1;
            tmo_d     = 4'd0;
            state_d   = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cs_d = 1'b1;
        if (flash_busy) begin
          cs_d    = 1'b0;
          state_d = S_WAIT;
        end else if (tmo_q == TMO_LAST) begin
          cs_d    = 1'b0;
          bo_d    = 1'b0;
          state_d = S_BACKOFF;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end

      S_BACKOFF: begin
        cs_d = 1'b0;
        if (flash_busy) begin
          // The withdrawn strobe was accepted after all.
          state_d = S_WAIT;
        end else if (bo_q) begin
          cs_d    = 1'b1;
          tmo_d   = 4'd0;
          state_d = S_ISSUE;
        end else begin
          bo_d = 1'b1;
        end
      end

      S_WAIT: begin
        cs_d = 1'b0;
        if (!flash_busy) begin
          ack_d[grant_q]  = 1'b1;
          dout_d[grant_q] = flash_dout;
          if (CACHE_EN && fill_ok_q) begin
            buf_addr_d[grant_q] = faddr_q;
            buf_data_d[grant_q] = flash_dout;
            buf_vld_d[grant_q]  = 1'b1;
          end
          // Keeps both the just-acked port and the strobe quiet for the ack
          // cycle and the one after it, so a fixed-priority port 0 that
          // re-requests right away still wins the next tie.
          hold_d  = 2'd2;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over any fill and stops an access in flight from filling.
    if (flush) begin
      buf_vld_d = '0;
      fill_ok_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= 4'd0;
      bo_q      <= 1'b0;
      hold_q    <= 2'd3;
      cs_q      <= 1'b0;
      faddr_q   <= '0;
      grant_q   <= 1'b0;
      rr_q      <= 1'b0;
      fill_ok_q <= 1'b0;
      ack_q     <= '0;
      ack_dly_q <= '0;
      buf_vld_q <= '0;
      for (int p = 0; p < 2; p++) begin
        dout_q[p]     <= '0;
        buf_addr_q[p] <= '0;
        buf_data_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      bo_q      <= bo_d;
      hold_q    <= hold_d;
      cs_q      <= cs_d;
      faddr_q   <= faddr_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      fill_ok_q <= fill_ok_d;
      ack_q     <= ack_d;
      ack_dly_q <= ack_q;
      buf_vld_q <= buf_vld_d;
      for (int p = 0; p < 2; p++) begin
        dout_q[p]     <= dout_d[p];
        buf_addr_q[p] <= buf_addr_d[p];
        buf_data_q[p] <= buf_data_d[p];
      end
    end
  end

  assign p0_ack     = ack_q[0];
  assign p1_ack     = ack_q[1];
  assign p0_dout    = dout_q[0];
  assign p1_dout    = dout_q[1];
  assign flash_cs   = cs_q;
  assign flash_addr = faddr_q;
  assign grant      = grant_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_arbiter
//
// Two arbiters, each with its own flash model: index 0 is round-robin,
// index 1 is fixed priority. The flash model sees flash_cs through two
// flops, answers a rising edge with 32 cycles of busy and then returns
// addr[15:0] ^ 16'hA5A5; it can be told to ignore a strobe.
// -----------------------------------------------------------------------------
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b00;
  logic [1:0]  ready = 2'b00;
  logic [1:0]  flush = 2'b00;
  logic [1:0]  req0 = 2'b00;
  logic [1:0]  req1 = 2'b00;
  logic [21:0] addr0 [2] = '{22'h0, 22'h0};
  logic [21:0] addr1 [2] = '{22'h0, 22'h0};
  logic [1:0]  ack0, ack1;
  logic [15:0] dout0 [2];
  logic [15:0] dout1 [2];
  logic [1:0]  f_cs;
  logic [21:0] f_addr [2];
  logic [1:0]  f_busy = 2'b00;
  logic [15:0] f_dout [2] = '{16'h0, 16'h0};
  logic [1:0]  grant;
  logic [1:0]  state [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- DUTs
  flash_arbiter #(.FIXED_PRIO(1'b0), .CACHE_EN(1'b1), .ISSUE_TIMEOUT(8)) u_rr (
    .clk(clk), .reset(rst[0]),
    .p0_req(req0[0]), .p0_addr(addr0[0]), .p0_ack(ack0[0]), .p0_dout(dout0[0]),
    .p1_req(req1[0]), .p1_addr(addr1[0]), .p1_ack(ack1[0]), .p1_dout(dout1[0]),
    .flush(flush[0]), .flash_ready(ready[0]), .flash_busy(f_busy[0]),
    .flash_dout(f_dout[0]), .flash_cs(f_cs[0]), .flash_addr(f_addr[0]),
    .grant(grant[0]), .dbg_state(state[0])
  );

  flash_arbiter #(.FIXED_PRIO(1'b1), .CACHE_EN(1'b1), .ISSUE_TIMEOUT(8)) u_fp (
    .clk(clk), .reset(rst[1]),
    .p0_req(req0[1]), .p0_addr(addr0[1]), .p0_ack(ack0[1]), .p0_dout(dout0[1]),
    .p1_req(req1[1]), .p1_addr(addr1[1]), .p1_ack(ack1[1]), .p1_dout(dout1[1]),
    .flush(flush[1]), .flash_ready(ready[1]), .flash_busy(f_busy[1]),
    .flash_dout(f_dout[1]), .flash_cs(f_cs[1]), .flash_addr(f_addr[1]),
    .grant(grant[1]), .dbg_state(state[1])
  );

  // ---------------------------------------------------------------- flash model + monitors
  logic [2:0]  sync [2] = '{3'b0, 3'b0};
  logic [21:0] lat  [2] = '{22'h0, 22'h0};
  int cnt          [2] = '{0, 0};
  int strobes      [2] = '{0, 0};
  int ignore_upto  [2] = '{0, 0};
  int rises        [2] = '{0, 0};
  int low_run      [2] = '{0, 0};
  int low_at_rise  [2] = '{0, 0};
  int cs_busy_viol [2] = '{0, 0};
  int a0cnt        [2] = '{0, 0};
  int a1cnt        [2] = '{0, 0};

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      sync[m] <= {sync[m][1:0], f_cs[m]};
      if (f_cs[m] && !sync[m][0]) begin
        rises[m]       <= rises[m] + 1;
        low_at_rise[m] <= low_run[m];
        if (f_busy[m]) cs_busy_viol[m] <= cs_busy_viol[m] + 1;
      end
      low_run[m] <= f_cs[m] ? 0 : low_run[m] + 1;
      if (ack0[m]) a0cnt[m] <= a0cnt[m] + 1;
      if (ack1[m]) a1cnt[m] <= a1cnt[m] + 1;
      if (sync[m][1] && !sync[m][2]) begin
        strobes[m] <= strobes[m] + 1;
        if (!f_busy[m] && strobes[m] >= ignore_upto[m]) begin
          f_busy[m] <= 1'b1;
          cnt[m]    <= 32;
          lat[m]    <= f_addr[m];
        end
      end else if (f_busy[m]) begin
        if (cnt[m] == 1) begin
          f_busy[m] <= 1'b0;
          f_dout[m] <= lat[m][15:0] ^ 16'hA5A5;
        end
        cnt[m] <= cnt[m] - 1;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Leaves the caller at the negedge of the ack cycle when ok=1.
  task automatic wait_ack(input int m, input int p, input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((p == 0) ? ack0[m] : ack1[m]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic ok;
  int base_r, base_a0, base_a1, n_hi, n_lo, viol;
  logic [15:0] exp_fp [3];

  initial begin
    exp_fp[0] = 16'hA4A5;
    exp_fp[1] = 16'hA4A4;
    exp_fp[2] = 16'hA4A7;

    #1 rst = 2'b11;
    cycles(3);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset_cs%0d", m), 32'(f_cs[m]), 32'd0);
      chk($sformatf("reset_addr%0d", m), 32'(f_addr[m]), 32'd0);
      chk($sformatf("reset_acks%0d", m), {30'd0, ack1[m], ack0[m]}, 32'd0);
      chk($sformatf("reset_douts%0d", m), {dout1[m], dout0[m]}, 32'd0);
      chk($sformatf("reset_grant%0d", m), 32'(grant[m]), 32'd0);
      chk($sformatf("reset_state%0d", m), 32'(state[m]), 32'd0);
    end

    // Test 1: requests wait for flash_ready.
    ready[1] = 1'b1;
    rst = 2'b00;
    req0[0] = 1'b1; addr0[0] = 22'h000123;
    n_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (f_cs[0] || ack0[0]) n_hi++;
    end
    chk("t1_quiet_not_ready", 32'(n_hi), 32'd0);
    base_r = rises[0]; base_a0 = a0cnt[0];
    ready[0] = 1'b1;
    wait_ack(0, 0, 200, ok);
    chk("t1_ack", 32'(ok), 32'd1);
    chk("t1_dout", 32'(dout0[0]), 32'hA486);
    req0[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack0[0]), 32'd0);
    cycles(5);
    chk("t1_one_ack", 32'(a0cnt[0] - base_a0), 32'd1);
    chk("t1_one_strobe", 32'(rises[0] - base_r), 32'd1);

    // Test 2: simultaneous requests, round-robin from port 0.
    rst[0] = 1'b1; cycles(2); rst[0] = 1'b0; cycles(4);
    base_r = rises[0]; base_a1 = a1cnt[0];
    req0[0] = 1'b1; addr0[0] = 22'h10;
    req1[0] = 1'b1; addr1[0] = 22'h20;
    wait_ack(0, 0, 200, ok);
    chk("t2_p0_ack", 32'(ok), 32'd1);
    chk("t2_p0_grant", 32'(grant[0]), 32'd0);
    chk("t2_p0_dout", 32'(dout0[0]), 32'hA5B5);
    chk("t2_p1_not_yet", 32'(a1cnt[0] - base_a1), 32'd0);
    req0[0] = 1'b0;
    wait_ack(0, 1, 200, ok);
    chk("t2_p1_ack", 32'(ok), 32'd1);
    chk("t2_p1_grant", 32'(grant[0]), 32'd1);
    chk("t2_p1_dout", 32'(dout1[0]), 32'hA585);
    req1[0] = 1'b0;
    chk("t2_two_strobes", 32'(rises[0] - base_r), 32'd2);
    chk("t2_cs_gap_ge2", 32'(low_at_rise[0] >= 2), 32'd1);

    // Test 3: buffer hit, then flush forces a flash access.
    cycles(3);
    base_r = rises[0];
    req1[0] = 1'b1; addr1[0] = 22'h20;
    @(negedge clk);
    chk("t3_hit_ack", 32'(ack1[0]), 32'd1);
    chk("t3_hit_dout", 32'(dout1[0]), 32'hA585);
    req1[0] = 1'b0;
    @(negedge clk);
    chk("t3_hit_ack_pulse", 32'(ack1[0]), 32'd0);
    cycles(3);
    chk("t3_hit_no_strobe", 32'(rises[0] - base_r), 32'd0);
    flush[0] = 1'b1; @(negedge clk); flush[0] = 1'b0;
    req1[0] = 1'b1;
    @(negedge clk);
    chk("t3_flushed_no_fast_ack", 32'(ack1[0]), 32'd0);
    wait_ack(0, 1, 200, ok);
    chk("t3_miss_ack", 32'(ok), 32'd1);
    chk("t3_miss_dout", 32'(dout1[0]), 32'hA585);
    chk("t3_miss_strobe", 32'(rises[0] - base_r), 32'd1);
    req1[0] = 1'b0;

    // Test 4: fixed priority, port 0 keeps re-requesting.
    base_a1 = a1cnt[1];
    req1[1] = 1'b1; addr1[1] = 22'h55;
    req0[1] = 1'b1; addr0[1] = 22'h100;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, 0, 200, ok);
      chk($sformatf("t4_p0_ack%0d", k), 32'(ok), 32'd1);
      chk($sformatf("t4_p0_grant%0d", k), 32'(grant[1]), 32'd0);
      chk($sformatf("t4_p0_dout%0d", k), 32'(dout0[1]), 32'(exp_fp[k]));
      chk($sformatf("t4_p1_starved%0d", k), 32'(a1cnt[1] - base_a1), 32'd0);
      req0[1] = 1'b0;
      @(negedge clk);
      if (k < 2) begin
        req0[1] = 1'b1; addr0[1] = addr0[1] + 22'd1;
      end
    end
    wait_ack(1, 1, 200, ok);
    chk("t4_p1_ack", 32'(ok), 32'd1);
    chk("t4_p1_grant", 32'(grant[1]), 32'd1);
    chk("t4_p1_dout", 32'(dout1[1]), 32'hA5F0);
    req1[1] = 1'b0;

    // Test 5: first strobe ignored, timeout and retry.
    cycles(3);
    ignore_upto[0] = strobes[0] + 1;
    req0[0] = 1'b1; addr0[0] = 22'h3AB;
    for (int i = 0; i < 50 && !f_cs[0]; i++) @(negedge clk);
    n_hi = 0;
    for (int i = 0; i < 40 && f_cs[0]; i++) begin n_hi++; @(negedge clk); end
    n_lo = 0;
    for (int i = 0; i < 40 && !f_cs[0]; i++) begin n_lo++; @(negedge clk); end
    chk("t5_cs_high_cycles", 32'(n_hi), 32'd8);
    chk("t5_backoff_cycles", 32'(n_lo), 32'd2);
    wait_ack(0, 0, 200, ok);
    chk("t5_ack", 32'(ok), 32'd1);
    chk("t5_dout", 32'(dout0[0]), 32'hA60E);
    req0[0] = 1'b0;

    // Test 6: reset during WAIT.
    cycles(3);
    req1[0] = 1'b1; addr1[0] = 22'h2B0;
    for (int i = 0; i < 50 && state[0] != 2'd3; i++) @(negedge clk);
    chk("t6_reached_wait", 32'(state[0]), 32'd3);
    cycles(5);
    base_a1 = a1cnt[0];
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t6_rst_cs", 32'(f_cs[0]), 32'd0);
    chk("t6_rst_ack", 32'(ack1[0]), 32'd0);
    chk("t6_rst_dout", 32'(dout1[0]), 32'd0);
    chk("t6_rst_state", 32'(state[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    viol = 0;
    for (int i = 0; i < 60 && f_busy[0]; i++) begin
      if (f_cs[0]) viol++;
      @(negedge clk);
    end
    chk("t6_busy_ended", 32'(f_busy[0]), 32'd0);
    chk("t6_no_strobe_while_busy", 32'(viol), 32'd0);
    chk("t6_no_stale_ack", 32'(a1cnt[0] - base_a1), 32'd0);
    wait_ack(0, 1, 200, ok);
    chk("t6_ack", 32'(ok), 32'd1);
    chk("t6_dout", 32'(dout1[0]), 32'hA715);
    req1[0] = 1'b0;
    cycles(3);

    chk("cs_rise_while_busy0", 32'(cs_busy_viol[0]), 32'd0);
    chk("cs_rise_while_busy1", 32'(cs_busy_viol[1]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
Name: flash_arbiter

Overview:
Shares the single DSPI flash read port between two word-read requesters. Port 0 is the chipset/CPU ROM fetch path. Port 1 is the floppy/HDD image loader. The block sequences the flash's edge-triggered cs/busy protocol and returns 16-bit words over a req/ack handshake. An optional one-entry last-word buffer per port short-circuits repeated reads of the same address.

Parameters:
FIXED_PRIO, 0, 1 = port 0 always wins when both request; 0 = round-robin between the ports.
CACHE_EN, 1, 1 = enable the per-port last-word buffer; 0 = every request goes to flash.
ISSUE_TIMEOUT, 8, number of cycles to wait for flash_busy after raising flash_cs before a retry (4..15).

Ports:
clk  in  1  system clock, same clock as the flash controller.
reset  in  1  asynchronous, active-high reset.
p0_req  in  1  port 0 read request; level, held until p0_ack.
p0_addr  in  22  port 0 word address; must be stable while p0_req=1.
p0_ack  out  1  one-cycle pulse; p0_dout is valid in this cycle.
p0_dout  out  16  port 0 read data.
p1_req, p1_addr, p1_ack, p1_dout  same as port 0, for port 1.
flush  in  1  invalidates both last-word buffers.
flash_ready  in  1  flash init phase has finished.
flash_busy  in  1  flash transfer in progress.
flash_dout  in  16  flash read data.
flash_cs  out  1  read strobe; the flash detects its rising edge through a 2-flop synchroniser.
flash_addr  out  22  word address to the flash.
grant  out  1  port of the current or last flash access (0/1), for debug.

Behaviour:
- Reset values: flash_cs=0, flash_addr=0, p0_ack=p1_ack=0, p0_dout=p1_dout=0, grant=0, both buffers invalid, round-robin pointer=0 (port 0 favoured first), state IDLE.
- Handshake: exactly one ack pulse per request. The ack is asserted one or more cycles after req is sampled high. The requester may drop req in the ack cycle or later. The arbiter does not re-grant a port in the cycle its ack is high, or in the following cycle.
- Cache hit: CACHE_EN=1, buffer valid, p_addr == stored address. Ack the cycle after req is sampled, with the stored data. No flash access. Hits are checked in IDLE only. Both ports may hit in the same cycle; each gets its own ack.
- IDLE: a flash access is issued only when flash_ready=1, flash_busy=0, and there is a pending non-hit request.
  - Winner: FIXED_PRIO=1 gives port 0. Otherwise the port the round-robin pointer favours; the pointer toggles to the other port after each granted flash access.
  - On grant, register flash_addr and grant, set flash_cs=1, go to ISSUE.
- ISSUE: hold flash_cs=1 until flash_busy=1 is sampled, then flash_cs=0 and go to WAIT. Minimum 2 cycles because of the synchroniser.
  - If ISSUE_TIMEOUT cycles pass without busy, go to BACKOFF.
- BACKOFF: flash_cs=0 for 2 cycles, then return to ISSUE with the same address. Retries are unlimited.
- WAIT: on the first cycle flash_busy=0, latch flash_dout into the granted port's dout and buffer (address + valid), pulse that port's ack, return to IDLE.
  - Flash-path latency from grant to ack = ISSUE (>=2) + transfer + 1.
- flash_cs must never rise while flash_busy=1. flash_cs is low for at least 2 cycles between accesses.
- flush: clears both valid bits in the cycle it is sampled.
  - If a flash access is in progress, its result still acks normally but is not written to the buffer.
  - flush has priority over the buffer fill in the same cycle.
- Mid-operation reset: return to IDLE with flash_cs=0 and no ack. After reset, no request is issued until flash_busy is sampled low, so a transfer still running in the flash is ignored.
- Requests arriving while flash_ready=0 stay pending; no ack is given until the flash is ready.
- Address compare is the full 22 bits.

Test Plan:
Flash model: 32-cycle busy, data = addr[15:0]^16'hA5A5.
1. After reset, hold flash_ready=0 for 50 cycles with p0_req, addr 22'h000123 -> no flash_cs during that time. After ready, flash_cs rises once, p0_ack pulses once, p0_dout=16'hA486.
2. p0 and p1 request on the same cycle, p0_addr=0x10, p1_addr=0x20, FIXED_PRIO=0 -> p0 served first with 16'hA5B5, then p1 with 16'hA585. grant sequence 0,1. flash_cs low for >=2 cycles between the two accesses.
3. Repeat p1 read of 0x20 after test 2 -> p1_ack exactly 1 cycle after req, p1_dout=16'hA585, flash_cs stays 0. Assert flush, then repeat the read -> flash access occurs.
4. FIXED_PRIO=1, p0 re-requests continuously while p1_req is held -> p1 is never granted while p0 is pending. p1 is served once p0 goes idle.
5. Flash model ignores the first strobe -> after 8 cycles flash_cs drops for 2 cycles, rises again, and the access completes with correct data.
6. Assert reset during WAIT -> no ack, flash_cs=0. After release, no new strobe until flash_busy=0, then the pending request completes correctly.
